// File: rtl/cursor_select.sv
// cursor_select: debounces the five game buttons, moves a wrap-around cursor over the
// 6x6 card grid and issues validated single-cycle card-select or reject events.
module cursor_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_a,
  input  logic        play_en,
  input  logic        lock,
  input  logic [35:0] matched,
  output logic [5:0]  cursor_addr,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic        select_pulse,
  output logic [5:0]  select_addr,
  output logic        select_second,
  output logic        reject_pulse
);

  localparam int unsigned NumBtn = 5;
  localparam int unsigned BtnUp  = 0;
  localparam int unsigned BtnDn  = 1;
  localparam int unsigned BtnLt  = 2;
  localparam int unsigned BtnRt  = 3;
  localparam int unsigned BtnA   = 4;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] deb_q, deb_d, deb_prev_q;
  logic [NumBtn-1:0] press_q;
  logic [CntW-1:0]   cnt_q [NumBtn];
  logic [CntW-1:0]   cnt_d [NumBtn];

  logic [2:0] row_q, row_d, col_q, col_d;
  logic [5:0] addr_q, addr_d;
  logic       pick_q, pick_d;
  logic [5:0] first_q, first_d;
  logic [5:0] sel_addr_q, sel_addr_d;
  logic       sel_second_q, sel_second_d;
  logic       sel_pulse_q, sel_pulse_d;
  logic       rej_pulse_q, rej_pulse_d;

  assign raw = {btn_a, btn_right, btn_left, btn_down, btn_up};

  // Debounce counters: count cycles of disagreement, flip the level on the last one.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Synchronizers, debounced levels and registered rising-edge press events.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Cursor movement and select validation; the A decision uses the pre-move address.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    pick_d       = pick_q;
    first_d      = first_q;
    sel_addr_d   = sel_addr_q;
    sel_second_d = sel_second_q;
    sel_pulse_d  = 1'b0;
    rej_pulse_d  = 1'b0;
    if (play_en) begin
      if (press_q[BtnA]) begin
        if (!lock && !matched[addr_q] && !(pick_q && (addr_q == first_q))) begin
          sel_pulse_d  = 1'b1;
          sel_addr_d   = addr_q;
          sel_second_d = pick_q;
          if (!pick_q) first_d = addr_q;
          pick_d = ~pick_q;
        end else begin
          rej_pulse_d = 1'b1;
        end
      end
      if (press_q[BtnUp] && !press_q[BtnDn]) begin
        row_d = (row_q == 3'd0) ? 3'd5 : row_q - 3'd1;
      end else if (press_q[BtnDn] && !press_q[BtnUp]) begin
        row_d = (row_q == 3'd5) ? 3'd0 : row_q + 3'd1;
      end
      if (press_q[BtnLt] && !press_q[BtnRt]) begin
        col_d = (col_q == 3'd0) ? 3'd5 : col_q - 3'd1;
      end else if (press_q[BtnRt] && !press_q[BtnLt]) begin
        col_d = (col_q == 3'd5) ? 3'd0 : col_q + 3'd1;
      end
    end else begin
      pick_d = 1'b0;
    end
    addr_d = 6'(row_d) * 6'd6 + 6'(col_d);
  end

  // Game-side state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      pick_q       <= 1'b0;
      first_q      <= '0;
      sel_addr_q   <= '0;
      sel_second_q <= 1'b0;
      sel_pulse_q  <= 1'b0;
      rej_pulse_q  <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      pick_q       <= pick_d;
      first_q      <= first_d;
      sel_addr_q   <= sel_addr_d;
      sel_second_q <= sel_second_d;
      sel_pulse_q  <= sel_pulse_d;
      rej_pulse_q  <= rej_pulse_d;
    end
  end

  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign cursor_addr   = addr_q;
  assign select_pulse  = sel_pulse_q;
  assign select_addr   = sel_addr_q;
  assign select_second = sel_second_q;
  assign reject_pulse  = rej_pulse_q;

endmodule

// File: tb/tb_cursor_select.sv
// tb_cursor_select: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a behavioural model of the game rules.
module tb_cursor_select;

  localparam int unsigned D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btn = '0;  // 0 up, 1 down, 2 left, 3 right, 4 a
  logic        play_en = 1'b1;
  logic        lock = 1'b0;
  logic [35:0] matched = '0;
  logic [5:0]  cursor_addr;
  logic [2:0]  cursor_row, cursor_col;
  logic        select_pulse, select_second, reject_pulse;
  logic [5:0]  select_addr;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  cursor_select #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_up       (btn[0]),
    .btn_down     (btn[1]),
    .btn_left     (btn[2]),
    .btn_right    (btn[3]),
    .btn_a        (btn[4]),
    .play_en      (play_en),
    .lock         (lock),
    .matched      (matched),
    .cursor_addr  (cursor_addr),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col),
    .select_pulse (select_pulse),
    .select_addr  (select_addr),
    .select_second(select_second),
    .reject_pulse (reject_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-button sample history and stable-run length, an event
  // pipeline of fixed depth, and the game rules on plain integer row/col.
  bit   m_s1 [5];
  bit   m_s2 [5];
  bit   m_deb [5];
  int   m_run [5];
  bit [4:0] m_ev1, m_ev2, ev, rising;
  int   m_row, m_col, m_pick, m_first, m_sel_addr, m_sel_second, m_sp, m_rp, addr;
  bit   s;

  always @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < 5; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_run[b] = 0;
      end
      m_ev1 = '0; m_ev2 = '0;
      m_row = 0; m_col = 0; m_pick = 0; m_first = 0;
      m_sel_addr = 0; m_sel_second = 0; m_sp = 0; m_rp = 0;
    end else begin
      ev = m_ev2;
      m_sp = 0;
      m_rp = 0;
      if (play_en) begin
        addr = m_row * 6 + m_col;
        if (ev[4]) begin
          if (!lock && !matched[addr] && !(m_pick == 1 && addr == m_first)) begin
            m_sp = 1;
            m_sel_addr = addr;
            m_sel_second = m_pick;
            if (m_pick == 0) m_first = addr;
            m_pick = 1 - m_pick;
          end else begin
            m_rp = 1;
          end
        end
        if (ev[0] && !ev[1]) m_row = (m_row + 5) % 6;
        if (ev[1] && !ev[0]) m_row = (m_row + 1) % 6;
        if (ev[2] && !ev[3]) m_col = (m_col + 5) % 6;
        if (ev[3] && !ev[2]) m_col = (m_col + 1) % 6;
      end else begin
        m_pick = 0;
      end
      m_ev2 = m_ev1;
      rising = '0;
      for (int b = 0; b < 5; b++) begin
        s = m_s2[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = btn[b];
        if (s != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == int'(D)) begin
            m_deb[b] = s;
            m_run[b] = 0;
            rising[b] = s;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_ev1 = rising;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("cursor_row", int'(cursor_row), m_row);
      chk("cursor_col", int'(cursor_col), m_col);
      chk("cursor_addr", int'(cursor_addr), m_row * 6 + m_col);
      chk("select_pulse", int'(select_pulse), m_sp);
      chk("select_addr", int'(select_addr), m_sel_addr);
      chk("select_second", int'(select_second), m_sel_second);
      chk("reject_pulse", int'(reject_pulse), m_rp);
      chk("pulse_exclusive", int'(select_pulse & reject_pulse), 0);
    end
  end

  // Press the buttons in mask together, hold, release; count pulses seen.
  int sp_cnt, rp_cnt, cap_addr, cap_second;
  task automatic press(input logic [4:0] mask);
    sp_cnt = 0; rp_cnt = 0; cap_addr = -1; cap_second = -1;
    btn = btn | mask;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) btn = btn & ~mask;
      @(negedge clock);
      if (select_pulse) begin
        sp_cnt++; cap_addr = int'(select_addr); cap_second = int'(select_second);
      end
      if (reject_pulse) rp_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clock);
    check_en = 1'b1;
    @(negedge clock);
    chk("reset_addr", int'(cursor_addr), 0);
    chk("reset_sel_addr", int'(select_addr), 0);

    // Hold right: first sampled at edge 0, cursor steps at edge 7 only.
    reset = 1'b0;
    btn[3] = 1'b1;
    repeat (7) @(negedge clock);
    chk("right_before_edge7", int'(cursor_col), 0);
    @(negedge clock);
    chk("right_at_edge7", int'(cursor_col), 1);
    repeat (12) @(negedge clock);
    chk("right_held_single", int'(cursor_col), 1);
    btn[3] = 1'b0;
    repeat (8) @(negedge clock);
    repeat (4) press(5'b01000);
    chk("right_to_5", int'(cursor_col), 5);
    press(5'b01000);
    chk("right_wrap_0", int'(cursor_col), 0);

    // Bounce down: 3 high, 1 low, then steady high.
    btn[1] = 1'b1;
    repeat (3) @(negedge clock);
    btn[1] = 1'b0;
    @(negedge clock);
    btn[1] = 1'b1;
    repeat (7) @(negedge clock);
    chk("bounce_no_move", int'(cursor_row), 0);
    @(negedge clock);
    chk("bounce_one_step", int'(cursor_row), 1);
    repeat (6) @(negedge clock);
    btn[1] = 1'b0;
    repeat (10) @(negedge clock);
    chk("bounce_single", int'(cursor_row), 1);

    // Move to (2,3) and select.
    press(5'b00010);
    repeat (3) press(5'b01000);
    chk("at_15", int'(cursor_addr), 15);
    press(5'b10000);
    chk("sel1_pulse", sp_cnt, 1);
    chk("sel1_addr", cap_addr, 15);
    chk("sel1_second", cap_second, 0);
    press(5'b10000);
    chk("resel_reject", rp_cnt, 1);
    chk("resel_no_sel", sp_cnt, 0);
    press(5'b01000);
    press(5'b10000);
    chk("sel2_addr", cap_addr, 16);
    chk("sel2_second", cap_second, 1);

    // Matched card and lock refusals.
    repeat (2) press(5'b00001);
    repeat (2) press(5'b01000);
    chk("at_0", int'(cursor_addr), 0);
    matched[0] = 1'b1;
    press(5'b10000);
    chk("matched_reject", rp_cnt, 1);
    press(5'b01000);
    lock = 1'b1;
    press(5'b10000);
    chk("lock_reject", rp_cnt, 1);
    lock = 1'b0;
    press(5'b10000);
    chk("unlock_accept", sp_cnt, 1);
    chk("unlock_second", cap_second, 0);
    matched[0] = 1'b0;

    // Simultaneous up/down at row 0, then left with A at (0,0).
    press(5'b00011);
    chk("updown_row", int'(cursor_row), 0);
    press(5'b00100);
    press(5'b10100);
    chk("leftA_addr", cap_addr, 0);
    chk("leftA_second", cap_second, 1);
    chk("leftA_col", int'(cursor_col), 5);

    // play_en drop resets the pick index; A while disabled is ignored.
    press(5'b10000);
    chk("pick1_second", cap_second, 0);
    play_en = 1'b0;
    press(5'b10000);
    chk("disabled_no_pulse", sp_cnt + rp_cnt, 0);
    play_en = 1'b1;
    press(5'b10000);
    chk("after_drop_sel", sp_cnt, 1);
    chk("after_drop_second", cap_second, 0);

    // Reset in the middle of debouncing A; A held through reset release.
    btn[4] = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_addr", int'(cursor_addr), 0);
    chk("rst_pulses", int'(select_pulse) + int'(reject_pulse), 0);
    chk("rst_second", int'(select_second), 0);
    reset = 1'b0;
    btn[4] = 1'b0;
    press(5'b10000);
    chk("post_rst_sel", sp_cnt, 1);

    // Randomized run.
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 6) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 99) == 0) play_en = ~play_en;
      if ($urandom_range(0, 29) == 0) lock = ~lock;
      if ($urandom_range(0, 199) == 0) begin
        matched = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      end
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    btn = '0;
    repeat (20) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
